// File: rtl/fetch_unit.sv
// fetch_unit: program-counter sequencer with an 8-entry branch-offset table.
// Optional build macro FETCH_CYCLE_COUNT_EN adds a 32-bit RUN-cycle counter
// output (cycle_count_o); without it the port and counter are absent.
module fetch_unit #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned OFF_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [7:0]       imem_data_i,
    input  logic             branchf_i,
    input  logic             branchb_i,
    input  logic             done_i,
    input  logic             lut_we_i,
    input  logic [2:0]       lut_waddr_i,
    input  logic [OFF_W-1:0] lut_wdata_i,
    output logic [PC_W-1:0]  imem_addr_o,
    output logic [7:0]       instruction_o,
    output logic             running_o,
    output logic             halted_o
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [31:0]      cycle_count_o
`endif
);

    localparam int unsigned LUT_N     = 8;
    localparam logic [7:0]  HALT_INSN = 8'h88;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic              running_q;
    logic              halted_q;
    logic [OFF_W-1:0]  lut_q [LUT_N];
    logic [PC_W-1:0]   offset;

    // Offset looked up from the registered table, so a same-cycle write is not yet visible
    assign offset = PC_W'(lut_q[imem_data_i[2:0]]);

    // State, PC and status flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == RUN);
            halted_q  <= (state_d == HALT);
        end
    end

    // Next state and next PC; done beats branches, forward beats backward
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (done_i) begin
                    state_d = HALT;
                end else if (branchf_i) begin
                    pc_d = pc_q + offset;
                end else if (branchb_i) begin
                    pc_d = pc_q - offset;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            HALT: begin
                if (start_i) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // Branch-offset table, writable in any state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we_i) begin
            lut_q[lut_waddr_i] <= lut_wdata_i;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] count_q;

    // RUN-cycle counter: cleared on RUN entry, frozen outside RUN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if ((state_q != RUN) && (state_d == RUN)) begin
            count_q <= '0;
        end else if (state_q == RUN) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign cycle_count_o = count_q;
`endif

    assign imem_addr_o   = pc_q;
    assign running_o     = running_q;
    assign halted_o      = halted_q;
    assign instruction_o = (state_q == RUN) ? imem_data_i : HALT_INSN;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference model feeds a scoreboard queue,
// plus directed absolute-value checks at the scenario points.
module tb_fetch_unit;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned OFF_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [7:0]       imem_data;
    logic             branchf;
    logic             branchb;
    logic             done;
    logic             lut_we;
    logic [2:0]       lut_waddr;
    logic [OFF_W-1:0] lut_wdata;
    logic [PC_W-1:0]  imem_addr;
    logic [7:0]       instruction;
    logic             running;
    logic             halted;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0]      cycle_count;
`endif

    fetch_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .imem_data_i   (imem_data),
        .branchf_i     (branchf),
        .branchb_i     (branchb),
        .done_i        (done),
        .lut_we_i      (lut_we),
        .lut_waddr_i   (lut_waddr),
        .lut_wdata_i   (lut_wdata),
        .imem_addr_o   (imem_addr),
        .instruction_o (instruction),
        .running_o     (running),
        .halted_o      (halted)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .cycle_count_o (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            run;
        logic            halt;
        logic [7:0]      instr;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = IDLE, 1 = RUN, 2 = HALT
    int              m_state;
    logic [PC_W-1:0] m_pc;
    logic [OFF_W-1:0] m_lut [8];
    logic [31:0]     m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = '0;
        m_count = '0;
        for (int i = 0; i < 8; i++) m_lut[i] = '0;
    endtask

    // One clock: drive at negedge, model pushes expectation, compare after the edge
    task automatic step(input logic st, input logic bf, input logic bb, input logic dn,
                        input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [7:0] im);
        exp_t e;
        exp_t got;
        logic [PC_W-1:0] off;
        @(negedge clk);
        start = st; branchf = bf; branchb = bb; done = dn;
        lut_we = we; lut_waddr = wa; lut_wdata = wd; imem_data = im;
        off = PC_W'(m_lut[im[2:0]]);
        case (m_state)
            0: begin
                m_pc = '0;
                if (st) begin m_state = 1; m_count = '0; end
            end
            1: begin
                m_count = m_count + 32'd1;
                if (dn) m_state = 2;
                else if (bf) m_pc = m_pc + off;
                else if (bb) m_pc = m_pc - off;
                else m_pc = m_pc + PC_W'(1);
            end
            default: begin
                if (st) begin m_state = 1; m_pc = '0; m_count = '0; end
            end
        endcase
        if (we) m_lut[wa] = wd;
        e.pc    = m_pc;
        e.run   = (m_state == 1);
        e.halt  = (m_state == 2);
        e.instr = (m_state == 1) ? im : 8'h88;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("pc", 32'(imem_addr), 32'(got.pc));
        check("running", 32'(running), 32'(got.run));
        check("halted", 32'(halted), 32'(got.halt));
        check("instruction", 32'(instruction), 32'(got.instr));
`ifdef FETCH_CYCLE_COUNT_EN
        check("cycle_count", cycle_count, m_count);
`endif
    endtask

    task automatic idle_step(input logic [7:0] im);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, im);
    endtask

    task automatic lut_write(input logic [2:0] wa, input logic [7:0] wd);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wa, wd, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; branchf = 1'b0; branchb = 1'b0; done = 1'b0;
        lut_we = 1'b0; lut_waddr = 3'd0; lut_wdata = '0; imem_data = 8'h00;
        model_reset();
        #12;
        check("rst_pc", 32'(imem_addr), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instr", 32'(instruction), 32'h88);
        @(negedge clk);
        rst_n = 1'b1;

        // Decoder inputs ignored in IDLE
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'h03);
        check("idle_pc", 32'(imem_addr), 32'd0);

        lut_write(3'd3, 8'd6);
        lut_write(3'd0, 8'd255);
        lut_write(3'd4, 8'd248);
        lut_write(3'd1, 8'd5);
        lut_write(3'd6, 8'd10);
        lut_write(3'd2, 8'd4);

        // Start then sequential fetch 0..5
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h10);
        check("start_pc0", 32'(imem_addr), 32'd0);
        for (int i = 0; i < 5; i++) idle_step(8'(i + 8'h20));
        check("seq_pc5", 32'(imem_addr), 32'd5);
        check("seq_running", 32'(running), 32'd1);

        // start ignored in RUN
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00);
        for (int i = 0; i < 4; i++) idle_step(8'h00);
        check("pc10", 32'(imem_addr), 32'd10);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'hA3);
        check("fwd_pc16", 32'(imem_addr), 32'd16);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'hA3);
        check("bwd_pc10", 32'(imem_addr), 32'd10);

        // Climb to 1023 then wrap forward, then wrap backward
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h04);
        check("pc1023", 32'(imem_addr), 32'd1023);
        idle_step(8'h00);
        check("wrap_fwd", 32'(imem_addr), 32'd0);
        idle_step(8'h00);
        idle_step(8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'h01);
        check("wrap_bwd", 32'(imem_addr), 32'd1021);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h06);
        check("pc7", 32'(imem_addr), 32'd7);

        // done overrides branch
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'h06);
        check("halt_pc7", 32'(imem_addr), 32'd7);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_instr", 32'(instruction), 32'h88);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h06);
        check("halt_ignore", 32'(imem_addr), 32'd7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00);
        check("restart_pc0", 32'(imem_addr), 32'd0);
        check("restart_run", 32'(running), 32'd1);

        // Same-cycle write and lookup: old value used, new one next cycle
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'd9, 8'h02);
        check("wr_old_pc4", 32'(imem_addr), 32'd4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h02);
        check("wr_new_pc13", 32'(imem_addr), 32'd13);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'h03);
        check("fwd_wins", 32'(imem_addr), 32'd19);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00);
        check("bwd_wrap", 32'(imem_addr), 32'd788);

        // Asynchronous reset mid-RUN, observed without a clock edge
        @(negedge clk);
        imem_data = 8'h5A;
        branchf = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb.delete();
        check("arst_pc", 32'(imem_addr), 32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_instr", 32'(instruction), 32'h88);
`ifdef FETCH_CYCLE_COUNT_EN
        check("arst_count", cycle_count, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        branchf = 1'b0;

        // Stays IDLE until start; table was cleared by reset
        for (int i = 0; i < 3; i++) idle_step(8'h03);
        check("post_rst_idle", 32'(running), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h03);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h03);
        check("lut_cleared", 32'(imem_addr), 32'd0);
        idle_step(8'h00);
        check("post_rst_inc", 32'(imem_addr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
